alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, two-stage pipelined successor to the 4-bit combinational ALU: a WIDTH-bit signed/unsigned arithmetic unit with eight operations, including saturating arithmetic, absolute difference, average and min/max. Valid/ready handshakes on input and output allow it to sit between operand-issue logic and a result consumer that may stall. Per-result flags and a sticky overflow status register are included.

## Interface
- `WIDTH`, default 8: operand/result width in bits, ≥ 2.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block accepts operands this cycle.
- `in_a`, `in_b` in WIDTH: operands, two's complement.
- `in_op` in 3: operation code.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_result` out WIDTH: result.
- `out_ovf`, `out_zero`, `out_neg` out 1 each: flags for `out_result`.
- `clr_sticky` in 1: clear sticky overflow.
- `sticky_ovf` out 1: set once any delivered result had `out_ovf`=1.

## Operation
- Ops:
  - 000 ADD: A+B, wrapped.
  - 001 SUB: A−B, wrapped.
  - 010 ABSDIFF: |A−B| of the wrapped difference; a difference of −2^(W−1) returns itself.
  - 011 AVG: the wrapped A+B, arithmetic-shifted right by 1.
  - 100 SADD: signed saturating A+B.
  - 101 SSUB: signed saturating A−B.
  - 110 MIN: signed minimum.
  - 111 MAX: signed maximum.
- Stage 1 registers the W-bit add/sub result, carry-out, signed overflow, operand sign bits and the op. ADD, AVG and SADD add; all other ops subtract.
- Stage 2 applies the post-processing: abs, shift, saturation or min/max select. It computes the flags and registers the outputs.
- `out_ovf` is the signed overflow of the internal add/sub for ADD, SUB, ABSDIFF and AVG. For SADD and SSUB, 1 means saturation occurred. MIN and MAX always give 0.
- `out_zero` is 1 when `out_result`==0.
- `out_neg` is `out_result[W−1]`.
- Saturation limits: positive overflow gives 2^(W−1)−1; negative overflow gives −2^(W−1).
- `sticky_ovf` is set on an output transfer (`out_valid`&&`out_ready`) with `out_ovf`=1. It is cleared by `clr_sticky`; if both occur in the same cycle, set wins.

## Timing
- Transfers occur on rising edges where valid&&ready.
- Latency: operands accepted at edge k give `out_valid`=1 after edge k+2.
- Throughput: one op per cycle while `out_ready`=1.
- Stall rules:
  - Stage 2 holds its contents while `out_valid`&&!`out_ready`.
  - Stage 1 advances when stage 2 is empty or draining.
  - `in_ready` = !s1_valid || s1_advance. `in_ready` depends combinationally on `out_ready`; there is no skid buffer.
- Output stability: while `out_valid`=1 and not accepted, `out_result` and all flags are held stable.
- No loss, duplication or reordering of operations under any stall pattern.
- Reset:
  - Asserting `rst` immediately forces `out_valid`=0, `out_result`=0, all flags 0, `sticky_ovf`=0 and the internal valids to 0.
  - `in_ready`=1 after release.
  - In-flight operations are discarded.
- `clr_sticky` takes effect at the next edge.

## Structure
- Package `alu_pkg`:
  - `alu_op_e`, a 3-bit enum with the eight codes above.
  - `alu_flags_t`, a struct of {ovf, zero, neg}.
  - Function `sat_limit(sign)`, templated on width through a parameter at the call site.
- Sub-module `alu_addsub` (combinational, WIDTH-parametrised):
  - Inputs: a, b, sub.
  - Outputs: sum, cout, ovf. ovf = carry into MSB XOR carry out.
  - Instantiated once in stage 1.
- Pipeline registers and the handshake logic live in `alu_pipe`.

## Test plan
All scenarios use WIDTH=8 unless noted.
- Flags and sticky:
  - ADD 0x7F+0x01 → result 0x80, ovf=1, neg=1, zero=0, `out_valid` two edges after acceptance; `sticky_ovf`=1 after transfer.
  - Then SUB 0x05−0x05 → 0x00, zero=1.
- Saturation:
  - SADD 0x7F+0x7F → 0x7F, ovf=1.
  - SSUB 0x80−0x01 → 0x80, ovf=1.
  - SADD 0x10+0x20 → 0x30, ovf=0.
- ABSDIFF / AVG:
  - ABSDIFF 0x03,0x05 → 0x02.
  - ABSDIFF 0x80,0x00 → 0x80.
  - AVG 0x05,0x07 → 0x06.
  - AVG 0xFF,0xFD → 0xFE.
  - MIN/MAX 0x80,0x7F → 0x80 / 0x7F, ovf=0.
- Backpressure:
  - Stream 6 ops with `out_ready` low for cycles 2–6: exactly 2 ops held in the pipe and `in_ready`=0.
  - On release, all 6 results emerge in order, one per cycle, with stable data while stalled.
- Reset mid-stream: with both stages full, pulse `rst` asynchronously (not edge-aligned) → `out_valid`, `sticky_ovf` and `out_result` all 0 immediately; first op after release has latency 2.
- Sticky clear collision: `clr_sticky`=1 in the same cycle as an ovf=1 transfer → `sticky_ovf` stays 1; `clr_sticky` alone next cycle → 0.
- Width: WIDTH=4, ADD 0x7+0x1 → 0x8, ovf=1.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_pkg : shared op codes, flag bundle and saturation-limit helper    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD     = 3'b000,
    OP_SUB     = 3'b001,
    OP_ABSDIFF = 3'b010,
    OP_AVG     = 3'b011,
    OP_SADD    = 3'b100,
    OP_SSUB    = 3'b101,
    OP_MIN     = 3'b110,
    OP_MAX     = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic ovf;
    logic zero;
    logic neg;
  } alu_flags_t;

  localparam int unsigned SAT_MAX_W = 64;

  // Caller passes its own width and truncates the result to that width.
  function automatic logic [SAT_MAX_W-1:0] sat_limit(input logic neg, input int unsigned w);
    logic [SAT_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < SAT_MAX_W; i++) begin
      if (i + 1 < w)       r[i] = ~neg;
      else if (i + 1 == w) r[i] = neg;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_addsub.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_addsub : combinational WIDTH-bit adder/subtractor with flags      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module alu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] w_b_x;
  logic [WIDTH-1:0] w_low;
  logic             w_c_msb;
  logic             w_msb;

  // Low W-1 bits are summed separately to expose the carry into the MSB.
  always_comb begin
    w_b_x   = b ^ {WIDTH{sub}};
    w_low   = {1'b0, a[WIDTH-2:0]} + {1'b0, w_b_x[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, sub};
    w_c_msb = w_low[WIDTH-1];
    {cout, w_msb} = {1'b0, a[WIDTH-1]} + {1'b0, w_b_x[WIDTH-1]} + {1'b0, w_c_msb};
    sum     = {w_msb, w_low[WIDTH-2:0]};
    ovf     = w_c_msb ^ cout;
  end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_pipe : two-stage valid/ready ALU with flags and sticky overflow   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  input  logic             clr_sticky,
  output logic             sticky_ovf
);

  alu_op_e          w_in_op;
  logic             w_in_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_s1_adv;
  logic             w_a_lt_b;
  logic [WIDTH-1:0] w_sat;
  logic [WIDTH-1:0] w_res;
  alu_flags_t       w_flags;

  logic             s1_valid_q, s1_valid_d;
  alu_op_e          s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [WIDTH-1:0] s1_sum_q, s1_sum_d;
  logic             s1_cout_q, s1_cout_d;
  logic             s1_ovf_q, s1_ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  alu_flags_t       out_flags_q, out_flags_d;
  logic             sticky_q, sticky_d;

  assign w_in_op  = alu_op_e'(in_op);
  assign w_in_sub = !(w_in_op inside {OP_ADD, OP_AVG, OP_SADD});

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (in_a),
    .b    (in_b),
    .sub  (w_in_sub),
    .sum  (w_sum),
    .cout (w_cout),
    .ovf  (w_ovf)
  );

  assign w_out_fire = out_valid_q & out_ready;
  assign w_s1_adv   = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready   = ~s1_valid_q | w_s1_adv;
  assign w_in_fire  = in_valid & in_ready;

  // Signed compare from the subtraction: differing signs decide directly,
  // otherwise a borrow (no carry out) means a < b.
  assign w_a_lt_b = (s1_a_q[WIDTH-1] ^ s1_b_q[WIDTH-1]) ? s1_a_q[WIDTH-1] : ~s1_cout_q;
  assign w_sat    = WIDTH'(sat_limit(s1_a_q[WIDTH-1], WIDTH));

  always_comb begin
    w_res        = s1_sum_q;
    w_flags      = '0;
    w_flags.ovf  = s1_ovf_q;
    case (s1_op_q)
      OP_ABSDIFF: if (s1_sum_q[WIDTH-1]) w_res = -s1_sum_q;
      OP_AVG:     w_res = {s1_sum_q[WIDTH-1], s1_sum_q[WIDTH-1:1]};
      OP_SADD,
      OP_SSUB:    if (s1_ovf_q) w_res = w_sat;
      OP_MIN: begin
        w_res       = w_a_lt_b ? s1_a_q : s1_b_q;
        w_flags.ovf = 1'b0;
      end
      OP_MAX: begin
        w_res       = w_a_lt_b ? s1_b_q : s1_a_q;
        w_flags.ovf = 1'b0;
      end
      default: ;
    endcase
    w_flags.zero = (w_res == '0);
    w_flags.neg  = w_res[WIDTH-1];
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_op_d      = s1_op_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_sum_d     = s1_sum_q;
    s1_cout_d    = s1_cout_q;
    s1_ovf_d     = s1_ovf_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;

    if (w_out_fire) out_valid_d = 1'b0;
    if (w_s1_adv) begin
      s1_valid_d   = 1'b0;
      out_valid_d  = 1'b1;
      out_result_d = w_res;
      out_flags_d  = w_flags;
    end
    if (w_in_fire) begin
      s1_valid_d = 1'b1;
      s1_op_d    = w_in_op;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_sum_d   = w_sum;
      s1_cout_d  = w_cout;
      s1_ovf_d   = w_ovf;
    end

    // Set takes priority over a simultaneous clear.
    sticky_d = (w_out_fire & out_flags_q.ovf) | (sticky_q & ~clr_sticky);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= OP_ADD;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_sum_q     <= '0;
      s1_cout_q    <= 1'b0;
      s1_ovf_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      sticky_q     <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_sum_q     <= s1_sum_d;
      s1_cout_q    <= s1_cout_d;
      s1_ovf_q     <= s1_ovf_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
      sticky_q     <= sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_ovf    = out_flags_q.ovf;
  assign out_zero   = out_flags_q.zero;
  assign out_neg    = out_flags_q.neg;
  assign sticky_ovf = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_alu_pipe : directed stimulus with queue scoreboard for alu_pipe    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_alu_pipe;

  typedef struct packed {
    logic [7:0] res;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_a, in_b, out_result;
  logic [2:0] in_op;
  logic       out_ovf, out_zero, out_neg, clr_sticky, sticky_ovf;

  logic       in4_valid, in4_ready, out4_valid, out4_ready;
  logic [3:0] in4_a, in4_b, out4_result;
  logic [2:0] in4_op;
  logic       out4_ovf, out4_zero, out4_neg, clr4_sticky, sticky4_ovf;

  exp_t       sb[$];
  exp_t       e;
  logic [4:0] sb4[$];
  logic [4:0] e4;
  int         checks = 0;
  int         errors = 0;
  int         accepted = 0;
  int         res_idx = 0;
  logic       held_v = 1'b0;
  logic [10:0] held;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_ovf(out_ovf), .out_zero(out_zero), .out_neg(out_neg),
    .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf)
  );

  alu_pipe #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in4_valid), .in_ready(in4_ready), .in_a(in4_a), .in_b(in4_b), .in_op(in4_op),
    .out_valid(out4_valid), .out_ready(out4_ready), .out_result(out4_result),
    .out_ovf(out4_ovf), .out_zero(out4_zero), .out_neg(out4_neg),
    .clr_sticky(clr4_sticky), .sticky_ovf(sticky4_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every transfer and guards data stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else if (out_valid) begin
      if (held_v) check("stall_hold", {out_result, out_ovf, out_zero, out_neg}, held);
      if (out_ready) begin
        held_v = 1'b0;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got %0h, expected no output", out_result);
        end else begin
          e = sb.pop_front();
          check($sformatf("result[%0d]", res_idx), {out_result, out_ovf, out_zero, out_neg},
                {e.res, e.ovf, e.res == 8'h00, e.res[7]});
          res_idx++;
        end
      end else begin
        held   = {out_result, out_ovf, out_zero, out_neg};
        held_v = 1'b1;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst && out4_valid && out4_ready) begin
      if (sb4.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output4: got %0h, expected no output", out4_result);
      end else begin
        e4 = sb4.pop_front();
        check("width4_result", {out4_result, out4_ovf, out4_zero, out4_neg},
              {e4[4:1], e4[0], e4[4:1] == 4'h0, e4[4]});
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic ovf);
    exp_t x;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    x.res = r; x.ovf = ovf;
    sb.push_back(x);
    for (int n = 0; n <= 50; n++) begin
      if (n == 50) begin
        checks++; errors++;
        $display("FAIL accept_timeout: got in_ready low for 50 cycles, expected acceptance");
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    accepted++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected earlier completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc0;
    int cnt;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    out_ready = 1'b1; clr_sticky = 1'b0;
    in4_valid = 1'b0; in4_a = '0; in4_b = '0; in4_op = '0; out4_ready = 1'b1; clr4_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_flags", {out_ovf, out_zero, out_neg}, 0);
    check("rst_sticky", sticky_ovf, 0);
    check("rst_in_ready", in_ready, 1);

    // Flags, latency and sticky set
    issue(3'b000, 8'h7F, 8'h01, 8'h80, 1'b1);
    check("lat_edge1", out_valid, 0);
    @(posedge clk); #1;
    check("lat_edge2", out_valid, 1);
    @(posedge clk); #1;
    check("sticky_set", sticky_ovf, 1);
    issue(3'b001, 8'h05, 8'h05, 8'h00, 1'b0);

    // Saturation, absdiff, average, min/max streamed back to back
    issue(3'b100, 8'h7F, 8'h7F, 8'h7F, 1'b1);
    issue(3'b101, 8'h80, 8'h01, 8'h80, 1'b1);
    issue(3'b100, 8'h10, 8'h20, 8'h30, 1'b0);
    issue(3'b010, 8'h03, 8'h05, 8'h02, 1'b0);
    issue(3'b010, 8'h80, 8'h00, 8'h80, 1'b0);
    issue(3'b011, 8'h05, 8'h07, 8'h06, 1'b0);
    issue(3'b011, 8'hFF, 8'hFD, 8'hFE, 1'b0);
    issue(3'b110, 8'h80, 8'h7F, 8'h80, 1'b0);
    issue(3'b111, 8'h80, 8'h7F, 8'h7F, 1'b0);
    repeat (3) @(posedge clk); #1;

    // WIDTH=4 instance
    in4_valid = 1'b1; in4_op = 3'b000; in4_a = 4'h7; in4_b = 4'h1;
    sb4.push_back({4'h8, 1'b1});
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in4_ready) break;
    end
    @(posedge clk); #1 in4_valid = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Backpressure: six ops with the consumer stalled early on
    acc0 = accepted;
    fork
      begin
        issue(3'b000, 8'h01, 8'h02, 8'h03, 1'b0);
        issue(3'b001, 8'h10, 8'h01, 8'h0F, 1'b0);
        issue(3'b111, 8'h05, 8'hFB, 8'h05, 1'b0);
        issue(3'b110, 8'h05, 8'hFB, 8'hFB, 1'b0);
        issue(3'b011, 8'h7F, 8'h01, 8'hC0, 1'b1);
        issue(3'b101, 8'h7F, 8'hFF, 8'h7F, 1'b1);
      end
      begin
        out_ready = 1'b0;
        repeat (5) @(posedge clk); #1;
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_held_ops", accepted - acc0, 2);
        out_ready = 1'b1;
        cnt = 0;
        repeat (6) begin
          @(negedge clk);
          if (out_valid) cnt++;
        end
        check("bp_back_to_back", cnt, 6);
      end
    join
    repeat (3) @(posedge clk); #1;

    // Asynchronous reset with both stages occupied
    out_ready = 1'b0;
    issue(3'b000, 8'h11, 8'h22, 8'h33, 1'b0);
    issue(3'b001, 8'h40, 8'h01, 8'h3F, 1'b0);
    check("pre_rst_sticky", sticky_ovf, 1);
    check("pre_rst_full", {out_valid, in_ready}, 2'b10);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_result", out_result, 0);
    check("rst_async_sticky", sticky_ovf, 0);
    check("rst_async_flags", {out_ovf, out_zero, out_neg}, 0);
    sb.delete();
    #3 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);
    issue(3'b000, 8'h20, 8'h22, 8'h42, 1'b0);
    check("post_rst_lat1", out_valid, 0);
    @(posedge clk); #1;
    check("post_rst_lat2", out_valid, 1);
    repeat (2) @(posedge clk); #1;

    // Sticky set/clear collision
    out_ready = 1'b0;
    issue(3'b100, 8'h80, 8'h80, 8'h80, 1'b1);
    @(posedge clk); #1;
    check("coll_valid", out_valid, 1);
    check("coll_sticky_before", sticky_ovf, 0);
    out_ready = 1'b1; clr_sticky = 1'b1;
    @(posedge clk); #1;
    check("sticky_collision", sticky_ovf, 1);
    @(posedge clk); #1;
    check("sticky_clear", sticky_ovf, 0);
    clr_sticky = 1'b0;

    for (int n = 0; n < 20 && (sb.size() != 0 || sb4.size() != 0); n++) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    check("sb4_drained", sb4.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
